// File: rtl/demux_1x2_8b_reg.sv
// Registered 1-to-2 byte demultiplexer with valid/ready handshaking.
// Each output channel is a one-entry register with a wrapping delivery counter.
module demux_1x2_8b_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       s,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out0_data,
  output logic [7:0] out1_data,
  output logic       out0_valid,
  output logic       out1_valid,
  input  logic       out0_ready,
  input  logic       out1_ready,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  logic       v0_q, v0_d, v1_q, v1_d;
  logic [7:0] d0_q, d0_d, d1_q, d1_d;
  logic [7:0] c0_q, c0_d, c1_q, c1_d;
  logic       free0, free1, acc0, acc1, dlv0, dlv1;

  always_comb begin
    free0    = !v0_q || out0_ready;
    free1    = !v1_q || out1_ready;
    in_ready = s ? free1 : free0;
    acc0     = in_valid && in_ready && !s;
    acc1     = in_valid && in_ready && s;
    dlv0     = v0_q && out0_ready;
    dlv1     = v1_q && out1_ready;

    v0_d = v0_q;
    d0_d = d0_q;
    c0_d = c0_q;
    v1_d = v1_q;
    d1_d = d1_q;
    c1_d = c1_q;

    // A load on the same edge as a delivery wins: valid stays set with new data.
    if (dlv0) begin
      v0_d = 1'b0;
      c0_d = c0_q + 8'd1;
    end
    if (acc0) begin
      v0_d = 1'b1;
      d0_d = in_data;
    end
    if (dlv1) begin
      v1_d = 1'b0;
      c1_d = c1_q + 8'd1;
    end
    if (acc1) begin
      v1_d = 1'b1;
      d1_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
      c0_q <= '0;
      c1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
    end
  end

  assign out0_valid = v0_q;
  assign out1_valid = v1_q;
  assign out0_data  = d0_q;
  assign out1_data  = d1_q;
  assign cnt0       = c0_q;
  assign cnt1       = c1_q;

endmodule

// File: tb/tb_demux_1x2_8b_reg.sv
// Scoreboard bench for demux_1x2_8b_reg: the driver queues accepted bytes per channel,
// a negedge monitor pops and compares on each delivery and tracks the expected counters.
module tb_demux_1x2_8b_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       s;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid;
  logic       out0_ready, out1_ready;
  logic [7:0] cnt0, cnt1;

  demux_1x2_8b_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .s          (s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         stalls = 0;
  logic [7:0] q [2][$];
  logic [7:0] exp_cnt [2];

  logic       vld [2];
  logic       rdy [2];
  logic [7:0] dat [2];
  logic [7:0] cnt [2];
  assign vld[0] = out0_valid;
  assign vld[1] = out1_valid;
  assign rdy[0] = out0_ready;
  assign rdy[1] = out1_ready;
  assign dat[0] = out0_data;
  assign dat[1] = out1_data;
  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented data with the queue head and pops on delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk($sformatf("cnt%0d", ch), cnt[ch], exp_cnt[ch]);
        if (vld[ch]) begin
          if (q[ch].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out%0d_unexpected: got valid data %0h expected no byte", ch, dat[ch]);
          end else begin
            chk($sformatf("out%0d_data", ch), dat[ch], q[ch][0]);
            if (rdy[ch]) begin
              void'(q[ch].pop_front());
              exp_cnt[ch] = exp_cnt[ch] + 8'd1;
            end
          end
        end else begin
          chk($sformatf("out%0d_pending", ch), q[ch].size(), 0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic sel);
    bit done;
    done = 1'b0;
    in_data  = d;
    s        = sel;
    in_valid = 1'b1;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        q[sel].push_back(d);
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk);
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no accept for %0h expected accept within 50 cycles", d);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    #1;
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 8'h00);
    chk("rst_out1_data", out1_data, 8'h00);
    chk("rst_cnt0", cnt0, 8'h00);
    chk("rst_cnt1", cnt1, 8'h00);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = 8'h77;
    s          = 1'b0;
    in_valid   = 1'b1;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;

    // Requests during reset must not be accepted.
    repeat (3) @(posedge clk);
    #1;
    chk("init_out0_valid", out0_valid, 0);
    chk("init_out0_data", out0_data, 8'h00);
    chk("init_cnt0", cnt0, 8'h00);
    chk("init_in_ready", in_ready, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte on channel 0.
    out0_ready = 1'b1;
    send(8'hA5, 1'b0);
    chk("s1_out0_valid", out0_valid, 1);
    chk("s1_out0_data", out0_data, 8'hA5);
    @(posedge clk);
    #1;
    chk("s1_out0_valid_drop", out0_valid, 0);
    chk("s1_cnt0", cnt0, 8'd1);
    chk("s1_out1_valid", out1_valid, 0);
    chk("s1_cnt1", cnt1, 8'd0);

    // Backpressure on channel 1.
    send(8'h3C, 1'b1);
    fork
      send(8'hC3, 1'b1);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out1_hold", out1_data, 8'h3C);
        end
        @(posedge clk);
        #1 out1_ready = 1'b1;
      end
    join
    chk("bp_cnt1_first", cnt1, 8'd1);
    chk("bp_out1_data", out1_data, 8'hC3);
    chk("bp_out1_valid", out1_valid, 1);
    @(posedge clk);
    #1;
    chk("bp_cnt1_second", cnt1, 8'd2);

    // Channel 0 blocked while channel 1 accepts.
    out0_ready = 1'b0;
    send(8'h5A, 1'b0);
    @(negedge clk);
    chk("cd_in_ready_s0", in_ready, 0);
    #1 s = 1'b1;
    #1 chk("cd_in_ready_s1", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h96, 1'b1);
    chk("cd_out0_data", out0_data, 8'h5A);
    chk("cd_out0_valid", out0_valid, 1);
    chk("cd_out1_data", out1_data, 8'h96);

    // Pending request retargeted from blocked channel 0 to channel 1.
    in_data  = 8'hE7;
    s        = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("sc_in_ready_s0", in_ready, 0);
    @(posedge clk);
    #1;
    chk("sc_out0_still", out0_data, 8'h5A);
    send(8'hE7, 1'b1);
    chk("sc_out1_data", out1_data, 8'hE7);
    chk("sc_out0_data", out0_data, 8'h5A);
    out0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sc_out0_drained", out0_valid, 0);

    // Streaming with alternating select.
    assert_reset();
    release_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 256; i++) send(8'(i), i[0]);
    @(posedge clk);
    #1;
    chk("st_stalls_256", stalls, 0);
    chk("st_cnt0_128", cnt0, 8'd128);
    chk("st_cnt1_128", cnt1, 8'd128);
    for (int i = 256; i < 512; i++) send(8'(i), i[0]);
    @(posedge clk);
    #1;
    chk("st_stalls_512", stalls, 0);
    chk("st_cnt0_wrap", cnt0, 8'd0);
    chk("st_cnt1_wrap", cnt1, 8'd0);

    // Asynchronous reset with both channels full.
    for (int k = 1; k <= 5; k++) send(8'(k), 1'b0);
    @(posedge clk);
    #1;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    chk("ar_cnt0", cnt0, 8'd5);
    chk("ar_out0_data", out0_data, 8'h11);
    chk("ar_out1_data", out1_data, 8'h22);
    assert_reset();
    release_reset();
    chk("ar_post_out0_valid", out0_valid, 0);
    chk("ar_post_cnt0", cnt0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1x2_8b_reg.md
# demux_1x2_8b_reg

Registered 1-to-2 byte demultiplexer with valid/ready handshaking, the distributing counterpart of the 8-bit 2:1 selector used on the ALU operand path. It accepts one 8-bit result per cycle from a single producer (ALU or sequential multiplier output stage) and routes it, under select `s`, into one of two single-entry output registers, each drained by an independent consumer. Each channel keeps a wrapping 8-bit count of delivered bytes for debug and verification.

## Interface
- No parameters; data width fixed at 8 bits.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset; clears all state immediately on assertion.
- `in_data` input 8 — byte to route.
- `s` input 1 — destination select: 0 → channel 0, 1 → channel 1; sampled with `in_valid`.
- `in_valid` input 1 — producer presents `in_data`/`s`.
- `in_ready` output 1 — the block will accept this cycle.
- `out0_data`, `out1_data` output 8 each — registered channel data.
- `out0_valid`, `out1_valid` output 1 each — the channel register holds an undelivered byte.
- `out0_ready`, `out1_ready` input 1 each — the consumer takes the byte this cycle.
- `cnt0`, `cnt1` output 8 each — bytes delivered per channel, mod 256.

## Operation
- Each channel has a one-entry register: data[7:0] and a full flag (`outN_valid`).
- Channel N is free when `!outN_valid || outN_ready`.
- `in_ready` is combinational: channel 1 free when `s`=1, channel 0 free when `s`=0. It depends on `s` and the selected channel only, never on `in_valid`.
- An accept occurs when `in_valid && in_ready`. On an accept, the selected channel loads `in_data` and sets valid. The unselected channel is unaffected.
- A delivery on channel N occurs when `outN_valid && outN_ready`. It clears valid unless the same edge also loads that channel; in that case valid stays 1 and the data is replaced with the new byte.
- Both channels may deliver on the same edge. One channel may deliver while the other is loaded.
- `cntN` increments by 1 on each delivery on channel N and wraps from 255 to 0.
- `outN_data` holds its value while `outN_valid`=1 and `outN_ready`=0. After a delivery, the data value is don't-care, but the RTL keeps the last value.
- If `s` changes while `in_valid`=0, nothing happens. If `s` changes while `in_valid`=1 and `in_ready`=0, this is legal: the target of the pending request moves and `in_ready` is recomputed.
- Reset: `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=8'h00, `cnt0`=`cnt1`=8'h00.
- During reset, `in_ready` follows the rule above with both channels empty, so it reads 1. No accept can occur while `rst_n`=0.
- Reset asserted mid-transfer discards held bytes and counts. No delivery is reported for discarded bytes.

## Timing
- Latency: a byte accepted at edge k is presented on `outN_data`/`outN_valid` after edge k. It can be delivered at edge k+1 at the earliest.
- Throughput: 1 byte per cycle into a channel whose consumer holds `outN_ready`=1. Alternating `s` with both consumers ready also gives 1 byte per cycle.
- Backpressure: when the selected channel is full and its `outN_ready`=0, `in_ready`=0. The producer must hold `in_data`/`s` stable until accepted.
- No combinational path from `in_valid` or `in_data` to any output. The only combinational paths are from `s` and `outN_ready` to `in_ready`.

## Test plan
- Reset then single byte: `rst_n` 0→1; `in_data`=8'hA5, `s`=0, `in_valid`=1 for one cycle, `out0_ready`=1 → `out0_valid`=1 for exactly one cycle with 8'hA5; `cnt0`=1; `out1_valid` stays 0; `cnt1`=0.
- Backpressure: `out1_ready`=0; send 8'h3C then 8'hC3 on `s`=1 → 8'h3C held on `out1_data`; `in_ready`=0 while 8'hC3 is pending. Raise `out1_ready` → 8'h3C delivered, then 8'hC3 loaded on the same edge; `cnt1` goes 1 then 2.
- Concurrent drain: channel 0 full and blocked (`out0_ready`=0); a request with `s`=1 is accepted in the same cycle → channel 0 unchanged, channel 1 loads; `in_ready`=1 for `s`=1 and 0 for `s`=0.
- Streaming/alternation: 256 bytes 0..255 with `s` alternating and both consumers always ready → no stalls; bytes arrive in order per channel; `cnt0`=`cnt1`=128. Continue to 512 bytes → both counters wrap to 0.
- Async reset mid-operation: both channels full with 8'h11/8'h22 and `cnt0`=5; drop `rst_n` between edges → all valids, data and counts read 0 immediately, without waiting for a clock edge.
- Select change under stall: `in_valid`=1, `s`=0, channel 0 blocked; switch `s` to 1 with channel 1 empty → accepted into channel 1 on the next edge.
